// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC constants used by router-side buffering blocks.
//                FLIT_WIDTH         - flit width in bits
//                DEFAULT_FIFO_DEPTH - default input-port FIFO depth (entries)
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int FLIT_WIDTH         = 64;
    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : flit_fifo
//  Description : Synchronous first-word-fall-through flit FIFO for router
//                input ports. Drop-in replacement for the single-entry buffer.
//
//  Parameters  : WIDTH     - flit width in bits
//                DEPTH     - entry count (power of two, >= 2)
//                AF_THRESH - count at/above which almost_full asserts
//
//  Ports       : clk         - clock, all state on rising edge
//                reset       - asynchronous active-high reset
//                read_req    - pop head entry (ignored when empty)
//                write_req   - push data_in (ignored when full)
//                data_in     - flit to store
//                data_out    - head entry, combinational (stale when empty)
//                full/empty  - count == DEPTH / count == 0
//                almost_full - count >= AF_THRESH
//                count       - occupied entries
//                overflow    - one-cycle pulse after a rejected write
//                underflow   - one-cycle pulse after a rejected read
//
//  Revision    : 1.0 - initial release
// ============================================================================
module flit_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH     = FLIT_WIDTH,
    parameter int DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         read_req,
    input  logic                         write_req,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_cnt   = c_cnt_w'(AF_THRESH);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_rd_en;
    logic               w_wr_en;
    logic [c_ptr_w-1:0] w_rd_prev;

    // Status flags come from the registered count alone.
    assign w_full      = (r_count == c_full_cnt);
    assign w_empty     = (r_count == '0);
    assign w_rd_en     = read_req  & ~w_empty;
    assign w_wr_en     = write_req & ~w_full;

    // While empty, rd_ptr already points past the last popped slot, so look
    // one slot back to keep presenting the flit that was just consumed.
    // DEPTH is a power of two, so the subtraction wraps naturally.
    assign w_rd_prev   = r_rd_ptr - c_ptr_one;

    assign data_out    = w_empty ? r_mem[w_rd_prev] : r_mem[r_rd_ptr];
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= c_af_cnt);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    // Storage entries, each cleared by reset so data_out reads 0 afterwards.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_mem[i] <= '0;
            end else if (w_wr_en && (r_wr_ptr == c_ptr_w'(i))) begin
                r_mem[i] <= data_in;
            end
        end
    end

    // Pointers, occupancy and error pulses. Pointer width equals log2(DEPTH),
    // so the increment wraps DEPTH-1 -> 0 without extra logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            r_overflow  <= write_req & w_full;
            r_underflow <= read_req  & w_empty;
        end
    end

endmodule : flit_fifo
`default_nettype wire

// File: doc/flit_fifo.md
FLIT_FIFO -- requirements
Module: flit_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 64: flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: entry count; power of two, minimum 2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-1: count at or above which almost_full asserts; range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port read_req, input, 1 bit: pop head entry.
REQ-007 SHALL have port write_req, input, 1 bit: push data_in.
REQ-008 SHALL have port data_in, input, WIDTH bits: flit to store.
REQ-009 SHALL have port data_out, output, WIDTH bits: current head entry (first-word-fall-through).
REQ-010 SHALL have port full, output, 1 bit: count == DEPTH.
REQ-011 SHALL have port empty, output, 1 bit: count == 0.
REQ-012 SHALL have port almost_full, output, 1 bit: count >= AF_THRESH.
REQ-013 SHALL have port count, output, $clog2(DEPTH+1) bits: occupied entries.
REQ-014 SHALL have port overflow, output, 1 bit: one-cycle pulse on a rejected write.
REQ-015 SHALL have port underflow, output, 1 bit: one-cycle pulse on a rejected read.

Function
REQ-016 SHALL define rd_en = read_req & !empty and wr_en = write_req & !full, both from pre-edge state.
REQ-017 SHALL accept rd_en and wr_en in the same cycle when neither full nor empty: head advances, new flit stored, count unchanged.
REQ-018 SHALL, when full with both requests, perform the read only; the write is rejected and overflow pulses.
REQ-019 SHALL, when empty with both requests, perform the write only; there is no bypass, the read is rejected and underflow pulses.
REQ-020 SHALL store a flit at wr_ptr on wr_en, then increment wr_ptr modulo DEPTH.
REQ-021 SHALL increment rd_ptr modulo DEPTH on rd_en; pointer wrap from DEPTH-1 to 0 SHALL be seamless.
REQ-022 SHALL drive data_out combinationally from the entry at rd_ptr, with zero latency from flit acceptance to head visibility.
REQ-023 SHALL keep data_out equal to the last popped slot's stored value while empty; the contents are stale, so consumers must gate on !empty.
REQ-024 SHALL update count as count + wr_en - rd_en each cycle.
REQ-025 SHALL derive full, empty and almost_full combinationally from count only.
REQ-026 SHALL assert overflow for exactly the cycle after an edge where write_req=1 and the write was rejected; underflow likewise for rejected reads.
REQ-027 SHALL emit flits in exact write order with no loss or duplication.

Reset
REQ-028 SHALL, on reset assertion, immediately clear rd_ptr, wr_ptr, count, overflow, underflow and all storage entries to 0, independent of clk.
REQ-029 SHALL present after reset: empty=1, full=0, almost_full=0, count=0, data_out=0.
REQ-030 SHALL discard in-flight requests when reset asserts mid-operation; the first accepted write after deassertion lands in entry 0.

Structure
REQ-031 SHALL take FLIT_WIDTH (64) and DEFAULT_FIFO_DEPTH (4) from the shared noc_pkg; the WIDTH and DEPTH defaults reference these.
REQ-032 SHALL be one module with no sub-modules; pointer and count logic stays inline.
REQ-033 SHALL behave as the existing single-entry buffer on full/empty/data_out for DEPTH=1-equivalent traffic, enabling drop-in replacement in router input ports.

Verification
REQ-034 SHALL test reset: assert reset mid-burst with 3 entries held -> empty=1, count=0, data_out=0 without a clk edge.
REQ-035 SHALL test fill and drain: DEPTH=4, write 0xA0..0xA3 -> full=1, almost_full=1 from count 3; then 4 reads -> data_out 0xA0,0xA1,0xA2,0xA3, then empty=1.
REQ-036 SHALL test overflow: full, write_req=1, read_req=0, data_in=0xFF -> overflow pulses 1 cycle, count stays 4, 0xFF never emerges.
REQ-037 SHALL test underflow: empty, read_req=1 -> underflow pulses 1 cycle, count stays 0; empty with both requests -> count becomes 1, underflow=1.
REQ-038 SHALL test simultaneous read/write: count=2, both requests for 10 cycles -> count stays 2, order preserved across pointer wrap.
REQ-039 SHALL test full with both requests: read performed, write rejected -> count=3, overflow=1.
